// File: rtl/template_match_ctrl.sv
// Frame sequencer for the waveform template matcher: clear, stream, settle, report.
// Optional TMC_VOTE_EN: 3-frame majority vote on the reported wave type.
module template_match_ctrl #(
  parameter int N_SAMPLES = 256,
  parameter int ADDR_W    = 8,
  parameter int SETTLE    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              frame_ready,
  output logic              frame_ack,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        sample_in,
  output logic [ADDR_W-1:0] tpl_addr,
  output logic [7:0]        wave_out,
  output logic [7:0]        dwave_out,
  output logic              wave_valid,
  output logic              match_clr,
  input  logic [1:0]        wave_type_in,
  output logic [1:0]        wave_type_out,
  output logic              type_valid,
  output logic              busy,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_SETTLE = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  // SETTLE state spans the 2-cycle pipeline drain plus SETTLE extra cycles.
  localparam int CNT_W = $clog2(SETTLE + 2);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(N_SAMPLES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort, rd_en_c, clr_c, report_c, latch_c;

  logic              rd_en_d1_q, wave_valid_q, first_q;
  logic [ADDR_W-1:0] tpl_addr_q;
  logic [7:0]        wave_q, dwave_q, prev_q;
  logic [1:0]        type_q, type_d;
  logic signed [9:0] diff;
  logic [7:0]        dwave_c;

  always_comb begin
    abort    = !enable && (state_q != S_IDLE);
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rd_en_c  = 1'b0;
    clr_c    = 1'b0;
    report_c = 1'b0;
    latch_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        cnt_d  = '0;
        if (enable && frame_ready) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr_c   = 1'b1;
        addr_d  = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        rd_en_c = 1'b1;
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          latch_c = 1'b1;
          state_d = S_REPORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REPORT: begin
        report_c = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d  = S_IDLE;
      addr_d   = '0;
      cnt_d    = '0;
      clr_c    = 1'b0;
      report_c = 1'b0;
      latch_c  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Derivative offset by 128, saturated to the 8-bit range.
  assign diff = signed'({2'b00, sample_in}) - signed'({2'b00, prev_q}) + 10'sd128;
  always_comb begin
    dwave_c = diff[7:0];
    if (first_q)                dwave_c = 8'd128;
    else if (diff < 10'sd0)     dwave_c = 8'd0;
    else if (diff > 10'sd255)   dwave_c = 8'd255;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_d1_q   <= 1'b0;
      wave_valid_q <= 1'b0;
      tpl_addr_q   <= '0;
      wave_q       <= '0;
      dwave_q      <= 8'd128;
      prev_q       <= '0;
      first_q      <= 1'b1;
    end else begin
      rd_en_d1_q   <= rd_en_c && !abort;
      wave_valid_q <= rd_en_d1_q && !abort;
      tpl_addr_q   <= addr_q;
      if (state_q == S_CLEAR) first_q <= 1'b1;
      if (rd_en_d1_q) begin
        wave_q  <= sample_in;
        dwave_q <= dwave_c;
        prev_q  <= sample_in;
        first_q <= 1'b0;
      end
    end
  end

`ifdef TMC_VOTE_EN
  logic [1:0] hist_q [3];

  // New result joins the two most recent ones; hold when all three differ.
  always_comb begin
    type_d = type_q;
    if (wave_type_in == hist_q[0] || wave_type_in == hist_q[1]) type_d = wave_type_in;
    else if (hist_q[0] == hist_q[1])                            type_d = hist_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q[0] <= 2'd0;
      hist_q[1] <= 2'd0;
      hist_q[2] <= 2'd0;
      type_q    <= 2'd0;
    end else if (latch_c) begin
      hist_q[0] <= wave_type_in;
      hist_q[1] <= hist_q[0];
      hist_q[2] <= hist_q[1];
      type_q    <= type_d;
    end
  end
`else
  assign type_d = wave_type_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          type_q <= 2'd0;
    else if (latch_c) type_q <= type_d;
  end
`endif

  assign frame_ack     = report_c;
  assign type_valid    = report_c;
  assign match_clr     = clr_c;
  assign rd_en         = rd_en_c;
  assign rd_addr       = addr_q;
  assign tpl_addr      = tpl_addr_q;
  assign wave_out      = wave_q;
  assign dwave_out     = dwave_q;
  assign wave_valid    = wave_valid_q;
  assign wave_type_out = type_q;
  assign busy          = (state_q != S_IDLE);
  assign state_dbg     = state_q;

endmodule
